// File: rtl/audio_level_meter.sv
// audio_level_meter: log-scaled (6 dB/LED) level bar for signed PCM samples.
// Tracks the window peak between display ticks, applies per-tick fall-off,
// peak hold and a stretched clip flag, and registers the LED pattern for the
// selected mode (bar, dot, bar+peak, raw top bits).
//
// Handshake: sample_valid is a valid-only strobe with no ready; the sample on
// sample_data is consumed in every cycle where sample_valid is high and can
// never be back-pressured.
module audio_level_meter #(
  parameter int DATA_WIDTH  = 24,
  parameter int NUM_LEDS    = 8,
  parameter int TICK_CYCLES = 833_333,
  parameter int HOLD_TICKS  = 15,
  parameter int CLIP_TICKS  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [1:0]            mode,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  clip
);

  localparam int MW     = DATA_WIDTH - 1;
  localparam int TW     = $clog2(TICK_CYCLES);
  localparam int LW     = $clog2(NUM_LEDS + 1);
  localparam int HW     = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int CW     = (CLIP_TICKS > 0) ? $clog2(CLIP_TICKS + 1) : 1;
  // acc bit index that maps to level 0; each higher bit adds one LED
  localparam int OFFSET = DATA_WIDTH - 2 - NUM_LEDS;

  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [MW-1:0]       acc_q, acc_d;
  logic [LW-1:0]       display_q, display_d;
  logic [LW-1:0]       peak_q, peak_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [CW-1:0]       clip_cnt_q, clip_cnt_d;
  logic [NUM_LEDS-1:0] raw_q, raw_d;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                clip_q, clip_d;

  logic [MW-1:0]       mag;
  logic                clip_evt;
  logic                tick;
  logic [LW-1:0]       new_level;
  logic [LW-1:0]       peak_dec;
  logic [NUM_LEDS-1:0] bar_pat, dot_pat, peak_pat;

  // Saturating magnitude of the incoming sample and clip-event detection
  always_comb begin
    mag = sample_data[MW-1:0];
    if (sample_data[DATA_WIDTH-1]) begin
      if (sample_data[MW-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = (~sample_data[MW-1:0]) + 1'b1;
      end
    end
    clip_evt = sample_valid &&
               ((sample_data == {1'b0, {MW{1'b1}}}) ||
                (sample_data == {1'b1, {MW{1'b0}}}));
  end

  // Level from the highest set bit of the window peak, clamped to 0..NUM_LEDS
  always_comb begin
    new_level = '0;
    for (int i = 0; i < MW; i++) begin
      if (acc_q[i]) begin
        if (i - OFFSET >= NUM_LEDS) begin
          new_level = LW'(NUM_LEDS);
        end else if (i - OFFSET > 0) begin
          new_level = LW'(i - OFFSET);
        end
      end
    end
  end

  assign tick = (tick_cnt_q == TW'(TICK_CYCLES - 1));

  // Window accumulation, tick-time display/peak/clip updates, raw capture
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    acc_d      = acc_q;
    display_d  = display_q;
    peak_d     = peak_q;
    hold_d     = hold_q;
    clip_cnt_d = clip_cnt_q;
    raw_d      = raw_q;
    peak_dec   = peak_q - 1'b1;
    if (tick) begin
      display_d = (new_level >= display_q) ? new_level : display_q - 1'b1;
      if (new_level >= peak_q) begin
        peak_d = new_level;
        hold_d = HW'(HOLD_TICKS);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        // peak_q > new_level >= 0 here, so peak_dec cannot underflow
        peak_d = (peak_dec > display_d) ? peak_dec : display_d;
      end
      // a sample arriving in the tick cycle opens the next window
      acc_d = sample_valid ? mag : '0;
      if (clip_cnt_q != '0) begin
        clip_cnt_d = clip_cnt_q - 1'b1;
      end
    end else if (sample_valid && (mag > acc_q)) begin
      acc_d = mag;
    end
    if (clip_evt) begin
      clip_cnt_d = CW'(CLIP_TICKS);
    end
    if (sample_valid) begin
      raw_d = sample_data[DATA_WIDTH-1 -: NUM_LEDS];
    end
  end

  // LED pattern for the current mode and the stretched clip flag
  always_comb begin
    bar_pat  = '0;
    dot_pat  = '0;
    peak_pat = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bar_pat[i]  = (LW'(i) < display_q);
      dot_pat[i]  = (LW'(i + 1) == display_q);
      peak_pat[i] = (LW'(i + 1) == peak_q);
    end
    case (mode)
      2'd0:    led_d = bar_pat;
      2'd1:    led_d = dot_pat;
      2'd2:    led_d = bar_pat | peak_pat;
      default: led_d = raw_q;
    endcase
    clip_d = (clip_cnt_q != '0);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      acc_q      <= '0;
      display_q  <= '0;
      peak_q     <= '0;
      hold_q     <= '0;
      clip_cnt_q <= '0;
      raw_q      <= '0;
      led_q      <= '0;
      clip_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      acc_q      <= acc_d;
      display_q  <= display_d;
      peak_q     <= peak_d;
      hold_q     <= hold_d;
      clip_cnt_q <= clip_cnt_d;
      raw_q      <= raw_d;
      led_q      <= led_d;
      clip_q     <= clip_d;
    end
  end

  assign led  = led_q;
  assign clip = clip_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Testbench for audio_level_meter (24-bit samples, 8 LEDs, 16-cycle ticks,
// 2-tick peak hold, 15-tick clip stretch).
module tb_audio_level_meter;

  localparam int DW = 24;
  localparam int NL = 8;
  localparam int TC = 16;
  localparam int HT = 2;
  localparam int CT = 15;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic [1:0]    mode = 2'd0;
  logic [NL-1:0] led;
  logic          clip;

  always #5 clk = ~clk;

  audio_level_meter #(
    .DATA_WIDTH (DW),
    .NUM_LEDS   (NL),
    .TICK_CYCLES(TC),
    .HOLD_TICKS (HT),
    .CLIP_TICKS (CT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .mode        (mode),
    .led         (led),
    .clip        (clip)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [NL:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Window contents kept as a list of magnitudes; levels computed by
  // counting the 6 dB thresholds the window maximum reaches.
  int m_win[$];
  int m_disp, m_peak, m_hold, m_ccnt, m_raw, m_cyc;

  function automatic int model_mag(input logic [DW-1:0] d);
    int v;
    v = int'(d);
    if (d[DW-1]) v = (1 << DW) - v;
    if (v > (1 << (DW - 1)) - 1) v = (1 << (DW - 1)) - 1;
    return v;
  endfunction

  function automatic int model_level(input int m);
    int lvl;
    lvl = 0;
    for (int k = 1; k <= NL; k++)
      if (m >= (1 << (DW - 2 - NL + k))) lvl = k;
    return lvl;
  endfunction

  function automatic logic [NL-1:0] model_decode(input int disp, input int pk,
                                                 input int raw, input logic [1:0] md);
    int bar, dot, mark;
    bar  = (1 << disp) - 1;
    dot  = (disp > 0) ? (1 << (disp - 1)) : 0;
    mark = (pk > 0) ? (1 << (pk - 1)) : 0;
    case (md)
      2'd0:    return NL'(bar);
      2'd1:    return NL'(dot);
      2'd2:    return NL'(bar | mark);
      default: return NL'(raw);
    endcase
  endfunction

  task automatic model_reset();
    m_win.delete();
    exp_q.delete();
    m_disp = 0; m_peak = 0; m_hold = 0; m_ccnt = 0; m_raw = 0; m_cyc = 0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic [1:0] md);
    int mx, lvl;
    logic clip_now;
    clip_now = (m_ccnt != 0);
    exp_q.push_back({clip_now, model_decode(m_disp, m_peak, m_raw, md)});
    if ((m_cyc % TC) == TC - 1) begin
      mx = 0;
      foreach (m_win[k]) if (m_win[k] > mx) mx = m_win[k];
      lvl = model_level(mx);
      m_disp = (lvl >= m_disp) ? lvl : m_disp - 1;
      if (lvl >= m_peak) begin
        m_peak = lvl;
        m_hold = HT;
      end else if (m_hold != 0) begin
        m_hold--;
      end else begin
        m_peak = (m_peak - 1 > m_disp) ? m_peak - 1 : m_disp;
      end
      m_win.delete();
      if (m_ccnt != 0) m_ccnt--;
    end
    if (v) begin
      m_win.push_back(model_mag(d));
      m_raw = int'(d[DW-1 -: NL]);
      if (d == 24'h7FFFFF || d == 24'h800000) m_ccnt = CT;
    end
    m_cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [DW-1:0] d);
    logic [NL:0] e;
    sample_valid = v;
    sample_data  = d;
    @(posedge clk);
    model_step(v, d, mode);
    #1;
    e = exp_q.pop_front();
    check("model_led", 32'(led), 32'(e[NL-1:0]));
    check("model_clip", 32'(clip), 32'(e[NL]));
    sample_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("reset_led", 32'(led), 32'h0);
    check("reset_clip", 32'(clip), 32'h0);
    rst_n = 1'b1;
  endtask

  // one sample at cycle 3 of the first window, stop one cycle after the tick
  task automatic one_window(input logic [DW-1:0] d);
    for (int j = 0; j <= TC; j++) step(j == 3, (j == 3) ? d : '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic [1:0]    md;
    logic [NL-1:0] exp_led;
    logic          exp_clip;
  } vec_t;

  vec_t vecs[13];
  logic [NL-1:0] decay_exp[10];

  initial begin
    logic          v;
    logic [DW-1:0] d;
    int            dens;

    vecs[0]  = '{"lvl_400000",  24'h400000, 2'd0, 8'hFF, 1'b0};
    vecs[1]  = '{"lvl_008000",  24'h008000, 2'd0, 8'h01, 1'b0};
    vecs[2]  = '{"lvl_007fff",  24'h007FFF, 2'd0, 8'h00, 1'b0};
    vecs[3]  = '{"lvl_c00000",  24'hC00000, 2'd0, 8'hFF, 1'b0};
    vecs[4]  = '{"sat_800000",  24'h800000, 2'd0, 8'hFF, 1'b1};
    vecs[5]  = '{"noclip_7ffffe", 24'h7FFFFE, 2'd0, 8'hFF, 1'b0};
    vecs[6]  = '{"clip_7fffff", 24'h7FFFFF, 2'd0, 8'hFF, 1'b1};
    vecs[7]  = '{"dot_lvl3",    24'h020000, 2'd1, 8'h04, 1'b0};
    vecs[8]  = '{"bar_lvl3",    24'h020000, 2'd0, 8'h07, 1'b0};
    vecs[9]  = '{"barpk_lvl3",  24'h020000, 2'd2, 8'h07, 1'b0};
    vecs[10] = '{"raw_a5",      24'hA51234, 2'd3, 8'hA5, 1'b0};
    vecs[11] = '{"lvl_minus1",  24'hFFFFFF, 2'd0, 8'h00, 1'b0};
    vecs[12] = '{"barpk_zero",  24'h000000, 2'd2, 8'h00, 1'b0};

    decay_exp = '{8'hFF, 8'hBF, 8'h5F, 8'h2F, 8'h17, 8'h0B, 8'h05, 8'h02, 8'h01, 8'h00};

    repeat (2) @(posedge clk);

    // table-driven single-window vectors
    foreach (vecs[i]) begin
      do_reset();
      mode = vecs[i].md;
      one_window(vecs[i].data);
      check({vecs[i].name, "_led"}, 32'(led), 32'(vecs[i].exp_led));
      check({vecs[i].name, "_clip"}, 32'(clip), 32'(vecs[i].exp_clip));
    end

    // decay with peak hold in bar+peak mode
    do_reset();
    mode = 2'd2;
    one_window(24'h400000);
    check("decay_t1", 32'(led), 32'hFF);
    for (int k = 0; k < 10; k++) begin
      run(TC);
      check("decay_tick", 32'(led), 32'(decay_exp[k]));
    end

    // clip latency and stretch length
    do_reset();
    mode = 2'd0;
    run(3);
    step(1'b1, 24'h800000);
    check("clip_lat1", 32'(clip), 32'h0);
    step(1'b0, '0);
    check("clip_lat2", 32'(clip), 32'h1);
    run(TC - 4);
    for (int k = 1; k <= CT + 1; k++) begin
      check("clip_hold", 32'(clip), 32'(k < CT));
      run(TC);
    end

    // sample in the tick cycle belongs to the next window
    do_reset();
    mode = 2'd0;
    run(TC - 1);
    step(1'b1, 24'h400000);
    step(1'b0, '0);
    check("collide_old", 32'(led), 32'h00);
    run(TC);
    check("collide_new", 32'(led), 32'hFF);

    // raw mode shows the top bits two cycles after the strobe
    do_reset();
    mode = 2'd3;
    step(1'b1, 24'hA5FFFF);
    check("raw_lat1", 32'(led), 32'h00);
    step(1'b0, '0);
    check("raw_lat2", 32'(led), 32'hA5);

    // reset mid-operation, then first tick timing
    do_reset();
    mode = 2'd0;
    one_window(24'h800000);
    check("pre_rst_led", 32'(led), 32'hFF);
    check("pre_rst_clip", 32'(clip), 32'h1);
    do_reset();
    step(1'b1, 24'h400000);
    run(TC - 1);
    check("first_tick_early", 32'(led), 32'h00);
    step(1'b0, '0);
    check("first_tick", 32'(led), 32'hFF);

    // randomized stimulus against the reference model
    do_reset();
    dens = 10;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if (n % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       dens = 0;
          1:       dens = 3;
          default: dens = 30;
        endcase
      end
      v = ($urandom_range(0, 99) < dens);
      case ($urandom_range(0, 5))
        0:       d = 24'h7FFFFF;
        1:       d = 24'h800000;
        2:       d = DW'($urandom_range(0, 1 << 16));
        3:       d = DW'($urandom) >> $urandom_range(0, 23);
        4:       d = -(DW'($urandom) >> $urandom_range(1, 23));
        default: d = DW'($urandom);
      endcase
      step(v, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
